// File: rtl/merge_stage_n.sv
// N-way merge stage: 4-phase Send/Ack input channels arbitrated into a DEPTH-entry FIFO,
// drained through a registered 4-phase output channel tagged with its source index.
module merge_stage_n #(
    parameter int WIDTH    = 38,
    parameter int NUM_IN   = 2,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 1,
    localparam int SW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                    CLK,
    input  logic                    MR,
    input  logic [NUM_IN-1:0]       Send_in,
    input  logic [NUM_IN*WIDTH-1:0] PACKET_IN,
    output logic [NUM_IN-1:0]       Ack_out,
    output logic                    Send_out,
    input  logic                    Ack_in,
    output logic [WIDTH-1:0]        PACKET_OUT,
    output logic [SW-1:0]           SRC_ID,
    output logic [CW-1:0]           COUNT
);

    typedef enum logic {C_IDLE, C_ACK} chan_state_e;
    typedef enum logic [1:0] {O_IDLE, O_SEND, O_RTZ} out_state_e;

    chan_state_e ch_q [NUM_IN];
    chan_state_e ch_d [NUM_IN];
    out_state_e  out_q, out_d;

    logic [NUM_IN-1:0]   ack_q, ack_d;
    logic                send_q, send_d;
    logic [WIDTH-1:0]    pkt_q, pkt_d;
    logic [SW-1:0]       src_q, src_d;
    logic [SW-1:0]       rr_q, rr_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SW+WIDTH-1:0] mem_q [DEPTH];

    logic [NUM_IN-1:0]   elig;
    logic                grant, push, pop;
    logic [SW-1:0]       gnt_idx;

    // Space is judged on the pre-pop occupancy, so a pop never frees room for a same-cycle push.
    always_comb begin
        int unsigned idx;
        logic [SW-1:0] sel;
        grant   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_IN; i++)
            elig[i] = (ch_q[i] == C_IDLE) && Send_in[i];
        if (count_q < CW'(DEPTH)) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                idx = (ARB_MODE == 1) ? k + 32'(rr_q) : k;
                if (idx >= NUM_IN)
                    idx = idx - NUM_IN;
                sel = SW'(idx);
                if (!grant && elig[sel]) begin
                    grant   = 1'b1;
                    gnt_idx = sel;
                end
            end
        end
    end

    assign push = grant;
    assign pop  = (out_q == O_SEND) && Ack_in;

    always_comb begin
        rr_d    = rr_q;
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (grant)
            rr_d = (32'(gnt_idx) == NUM_IN - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Channel FSMs: next state
    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            ch_d[i] = ch_q[i];
            case (ch_q[i])
                C_IDLE:  if (grant && gnt_idx == SW'(i)) ch_d[i] = C_ACK;
                C_ACK:   if (!Send_in[i]) ch_d[i] = C_IDLE;
                default: ch_d[i] = C_IDLE;
            endcase
        end
    end

    // Output FSM: next state
    always_comb begin
        out_d = out_q;
        case (out_q)
            O_IDLE:  if (count_q != '0) out_d = O_SEND;
            O_SEND:  if (Ack_in) out_d = O_RTZ;
            O_RTZ:   if (!Ack_in) out_d = O_IDLE;
            default: out_d = O_IDLE;
        endcase
    end

    // Registered outputs
    always_comb begin
        send_d = send_q;
        pkt_d  = pkt_q;
        src_d  = src_q;
        for (int unsigned i = 0; i < NUM_IN; i++)
            ack_d[i] = (ch_d[i] == C_ACK);
        if (out_q == O_IDLE && count_q != '0) begin
            {src_d, pkt_d} = mem_q[rptr_q];
            send_d         = 1'b1;
        end
        if (pop)
            send_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            for (int unsigned i = 0; i < NUM_IN; i++)
                ch_q[i] <= C_IDLE;
            out_q   <= O_IDLE;
            ack_q   <= '0;
            send_q  <= 1'b0;
            pkt_q   <= '0;
            src_q   <= '0;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++)
                ch_q[i] <= ch_d[i];
            out_q   <= out_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            pkt_q   <= pkt_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !MR)
            mem_q[wptr_q] <= {gnt_idx, PACKET_IN[gnt_idx*WIDTH +: WIDTH]};
    end

    assign Ack_out    = ack_q;
    assign Send_out   = send_q;
    assign PACKET_OUT = pkt_q;
    assign SRC_ID     = src_q;
    assign COUNT      = count_q;

endmodule
